spi_flash_sequencer: RTL and testbench

- Multi-byte SPI transaction sequencer that sits in front of the single-byte SPI engine (spi_controller) and drives it through that engine's axiiv/axiid/axiov/axiod/axiready handshake.
- Takes one command (opcode, optional address, optional read or write data phase) and issues the bytes MSB-first, one engine byte at a time.
- Owns the device chip select and holds it low across the whole transaction; the engine's own spi_cs_n is left unconnected at top level.
- Read bytes return as a pulse stream; write bytes are pulled from a ready/valid stream.

---
 rtl/spi_flash_sequencer_pkg.sv | 22 ++
 rtl/spi_flash_sequencer_if.sv | 59 +++++
 rtl/spi_flash_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_flash_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_sequencer_pkg.sv
// Shared types for the SPI flash sequencer: FSM states, byte phases, byte width.
// Imported by the sequencer interface and the sequencer top.
package spi_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    ISSUE,
    WAIT_RESP,
    CS_HOLD,
    CS_HIGH
  } state_e;

  typedef enum logic [1:0] {
    OPC,
    ADDR,
    DATA
  } phase_e;

endpackage

// File: rtl/spi_flash_sequencer_if.sv
// Sequencer bundle: command, write stream, read stream, chip select, engine side.
// slave = sequencer side, master = host/engine side.
interface spi_flash_sequencer_if #(
  parameter int ADDR_BYTES = 3,
  parameter int MAX_LEN    = 256
);
  import spi_seq_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int AW    = BYTE_W * ADDR_BYTES;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [BYTE_W-1:0] cmd_opcode;
  logic              cmd_addr_en;
  logic [AW-1:0]     cmd_addr;
  logic              cmd_write;
  logic [LEN_W-1:0]  cmd_len;

  logic [BYTE_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [BYTE_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;

  logic              busy;
  logic              dev_cs_n;

  logic              eng_axiiv;
  logic [BYTE_W-1:0] eng_axiid;
  logic              eng_axiov;
  logic [BYTE_W-1:0] eng_axiod;
  logic              eng_axiready;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_addr_en,
    input  cmd_addr, cmd_write, cmd_len,
    input  wr_data, wr_valid,
    input  eng_axiov, eng_axiod, eng_axiready,
    output cmd_ready, wr_ready,
    output rd_data, rd_valid, rd_last,
    output busy, dev_cs_n,
    output eng_axiiv, eng_axiid
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_addr_en,
    output cmd_addr, cmd_write, cmd_len,
    output wr_data, wr_valid,
    output eng_axiov, eng_axiod, eng_axiready,
    input  cmd_ready, wr_ready,
    input  rd_data, rd_valid, rd_last,
    input  busy, dev_cs_n,
    input  eng_axiiv, eng_axiid
  );

endinterface

// File: rtl/spi_flash_sequencer.sv
// Multi-byte SPI command sequencer driving a single-byte engine, owning CS.
// Ports: clk, rst (async high), bus (sequencer slave modport).
module spi_flash_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          ADDR_BYTES      = 3,
  parameter int          MAX_LEN         = 256,
  parameter int          CS_GUARD_CYCLES = 50,
  parameter logic [7:0]  DUMMY_BYTE      = 8'h00
) (
  input logic                  clk,
  input logic                  rst,
  spi_flash_sequencer_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(ADDR_BYTES + MAX_LEN + 2);
  localparam int GRD_W = $clog2(CS_GUARD_CYCLES + 1);
  localparam int AW    = BYTE_W * ADDR_BYTES;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(CS_GUARD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [GRD_W-1:0]  grd_q, grd_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  tot_q, tot_d;
  logic [BYTE_W-1:0] opc_q, opc_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              aen_q, aen_d;
  logic              wr_q, wr_d;

  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              cs_n_q, cs_n_d;
  logic              iv_q, iv_d;
  logic [BYTE_W-1:0] id_q, id_d;
  logic              wrr_q, wrr_d;
  logic              rdv_q, rdv_d;
  logic              rdl_q, rdl_d;
  logic [BYTE_W-1:0] rdd_q, rdd_d;

  phase_e            phase;
  logic [AW-1:0]     addr_sh;
  logic [BYTE_W-1:0] tx_byte;
  logic [LEN_W-1:0]  len_sat;
  logic [IDX_W-1:0]  idx_nxt;
  logic              grd_done;
  logic              last_b;

  assign grd_done = (grd_q == GRD_LAST);
  assign idx_nxt  = idx_q + 1'b1;
  assign last_b   = (idx_nxt == tot_q);
  assign len_sat  = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;

  // Phase follows the byte index: 0 is opcode, then address, then data.
  always_comb begin
    phase = DATA;
    if (idx_q == '0)
      phase = OPC;
    else if (aen_q && idx_q <= IDX_W'(ADDR_BYTES))
      phase = ADDR;
  end

  // Address bytes go out most-significant first.
  always_comb begin
    addr_sh = '0;
    if (phase == ADDR)
      addr_sh = addr_q >> (BYTE_W * (ADDR_BYTES - int'(idx_q)));
    case (phase)
      OPC:     tx_byte = opc_q;
      ADDR:    tx_byte = addr_sh[BYTE_W-1:0];
      default: tx_byte = wr_q ? bus.wr_data : DUMMY_BYTE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grd_d   = grd_q;
    idx_d   = idx_q;
    tot_d   = tot_q;
    opc_d   = opc_q;
    addr_d  = addr_q;
    aen_d   = aen_q;
    wr_d    = wr_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    cs_n_d  = cs_n_q;
    id_d    = id_q;
    rdd_d   = rdd_q;
    iv_d    = 1'b0;
    wrr_d   = 1'b0;
    rdv_d   = 1'b0;
    rdl_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && rdy_q) begin
          opc_d   = bus.cmd_opcode;
          addr_d  = bus.cmd_addr;
          aen_d   = bus.cmd_addr_en;
          wr_d    = bus.cmd_write;
          tot_d   = IDX_W'(1)
                  + (bus.cmd_addr_en ? IDX_W'(ADDR_BYTES) : '0)
                  + IDX_W'(len_sat);
          idx_d   = '0;
          grd_d   = '0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (grd_done) begin
          grd_d   = '0;
          state_d = ISSUE;
        end else begin
          grd_d = grd_q + 1'b1;
        end
      end
      ISSUE: begin
        // Write data stalls here (CS held) until the stream has a byte.
        if (bus.eng_axiready &&
            (phase != DATA || !wr_q || bus.wr_valid)) begin
          iv_d    = 1'b1;
          id_d    = tx_byte;
          wrr_d   = (phase == DATA) && wr_q;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (bus.eng_axiov) begin
          if (phase == DATA && !wr_q) begin
            rdv_d = 1'b1;
            rdd_d = bus.eng_axiod;
            rdl_d = last_b;
          end
          idx_d = idx_nxt;
          if (last_b) begin
            grd_d   = '0;
            state_d = CS_HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      CS_HOLD: begin
        if (grd_done) begin
          grd_d   = '0;
          cs_n_d  = 1'b1;
          state_d = CS_HIGH;
        end else begin
          grd_d = grd_q + 1'b1;
        end
      end
      CS_HIGH: begin
        if (grd_done) begin
          grd_d   = '0;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          grd_d = grd_q + 1'b1;
        end
      end
      default: begin
        grd_d   = '0;
        state_d = CS_HIGH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CS_HIGH;
      grd_q   <= '0;
      idx_q   <= '0;
      tot_q   <= '0;
      opc_q   <= '0;
      addr_q  <= '0;
      aen_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      iv_q    <= 1'b0;
      id_q    <= '0;
      wrr_q   <= 1'b0;
      rdv_q   <= 1'b0;
      rdl_q   <= 1'b0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      grd_q   <= grd_d;
      idx_q   <= idx_d;
      tot_q   <= tot_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      aen_q   <= aen_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      iv_q    <= iv_d;
      id_q    <= id_d;
      wrr_q   <= wrr_d;
      rdv_q   <= rdv_d;
      rdl_q   <= rdl_d;
      rdd_q   <= rdd_d;
    end
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.dev_cs_n  = cs_n_q;
  assign bus.eng_axiiv = iv_q;
  assign bus.eng_axiid = id_q;
  assign bus.wr_ready  = wrr_q;
  assign bus.rd_valid  = rdv_q;
  assign bus.rd_last   = rdl_q;
  assign bus.rd_data   = rdd_q;

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer with a behavioural byte engine.
// Engine answers byte n of each CS-low window with 0xA0+n.
module tb_spi_flash_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_flash_sequencer_if #(.ADDR_BYTES(3), .MAX_LEN(256)) bus ();

  spi_flash_sequencer #(
    .ADDR_BYTES     (3),
    .MAX_LEN        (256),
    .CS_GUARD_CYCLES(50),
    .DUMMY_BYTE     (8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] rd_q[$];
  int         busy_cnt;
  logic [7:0] bidx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.eng_axiready <= 1'b1;
      bus.eng_axiov    <= 1'b0;
      bus.eng_axiod    <= 8'h00;
      busy_cnt         <= 0;
      bidx             <= 8'h00;
    end else begin
      bus.eng_axiov <= 1'b0;
      if (bus.eng_axiiv && bus.eng_axiready) begin
        bus.eng_axiready <= 1'b0;
        busy_cnt         <= 3;
        rx_q.push_back(bus.eng_axiid);
      end else if (busy_cnt == 1) begin
        busy_cnt         <= 0;
        bus.eng_axiov    <= 1'b1;
        bus.eng_axiod    <= 8'hA0 + bidx;
        bidx             <= bidx + 8'h01;
        bus.eng_axiready <= 1'b1;
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end
      if (bus.dev_cs_n) bidx <= 8'h00;
    end
  end

  int   iv_cnt = 0, rd_cnt = 0, acc_cnt = 0, wrr_cnt = 0;
  int   last_cnt = 0, last_pos = 0;
  int   cs_rise = 0, cs_low = 0, hi_run = 0, hi_gap = 0;
  logic cs_prev = 1'b1;

  always @(negedge clk) begin
    if (bus.eng_axiiv) iv_cnt++;
    if (bus.wr_ready) wrr_cnt++;
    if (bus.cmd_valid && bus.cmd_ready) acc_cnt++;
    if (bus.rd_valid) begin
      rd_cnt++;
      rd_q.push_back(bus.rd_data);
    end
    if (bus.rd_last) begin
      last_cnt++;
      last_pos = rd_cnt;
    end
    if (bus.dev_cs_n) begin
      hi_run++;
      if (!cs_prev) cs_rise++;
    end else begin
      if (cs_prev) hi_gap = hi_run;
      hi_run = 0;
      cs_low++;
    end
    cs_prev = bus.dev_cs_n;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] opc, input logic aen,
                          input logic [23:0] addr, input logic wr,
                          input int len);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 500) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_opcode  = opc;
    bus.cmd_addr_en = aen;
    bus.cmd_addr    = addr;
    bus.cmd_write   = wr;
    bus.cmd_len     = 9'(len);
    bus.cmd_valid   = 1'b1;
    step();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < limit) begin
      step();
      n++;
    end
    chk("idle_wait", bus.cmd_ready, 1);
  endtask

  task automatic chk_tx(input string tag, input int base,
                        input logic [7:0] e0, input logic [7:0] e1,
                        input int idx);
    if (base + idx < rx_q.size())
      chk(tag, rx_q[base + idx], (idx == 0) ? e0 : e1);
    else
      chk(tag, -1, (idx == 0) ? e0 : e1);
  endtask

  logic [7:0] exp_rd[8] = '{8'h03, 8'h01, 8'h23, 8'h45,
                            8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_wr[6] = '{8'h02, 8'h00, 8'h00, 8'h10,
                            8'h55, 8'hAA};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ivb, rxb, rdb, lb, rb, wb, ab, clb;
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = '0;
    bus.cmd_addr_en = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_write   = 1'b0;
    bus.cmd_len     = '0;
    bus.wr_data     = '0;
    bus.wr_valid    = 1'b0;
    repeat (3) step();

    chk("rst_cs_n", bus.dev_cs_n, 1);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_axiiv", bus.eng_axiiv, 0);
    chk("rst_axiid", bus.eng_axiid, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_rd_data", bus.rd_data, 0);

    rst = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      step();
      n++;
    end
    chk("rst_to_ready", n, 50);

    // Read: opcode 03, address 012345, four data bytes.
    ivb = iv_cnt; rxb = rx_q.size(); rdb = rd_cnt;
    lb = last_cnt; rb = cs_rise;
    send_cmd(8'h03, 1'b1, 24'h012345, 1'b0, 4);
    chk("rd_busy", bus.busy, 1);
    chk("rd_cs_low", bus.dev_cs_n, 0);
    chk("rd_cmd_ready_low", bus.cmd_ready, 0);
    wait_idle(2000);
    chk("rd_tx_count", rx_q.size() - rxb, 8);
    for (int i = 0; i < 8; i++)
      chk_tx($sformatf("rd_tx%0d", i), rxb + i, exp_rd[i], exp_rd[i], 0);
    chk("rd_iv_pulses", iv_cnt - ivb, 8);
    chk("rd_valid_count", rd_cnt - rdb, 4);
    for (int i = 0; i < 4; i++)
      if (rdb + i < rd_q.size())
        chk($sformatf("rd_data%0d", i), rd_q[rdb + i], 8'hA4 + i);
    chk("rd_last_count", last_cnt - lb, 1);
    chk("rd_last_pos", last_pos - rdb, 4);
    chk("rd_cs_rises", cs_rise - rb, 1);

    // Write: opcode 02, address 000010, 55 then AA after a stall.
    ivb = iv_cnt; rxb = rx_q.size(); rdb = rd_cnt;
    rb = cs_rise; wb = wrr_cnt;
    send_cmd(8'h02, 1'b1, 24'h000010, 1'b1, 2);
    n = 0;
    while (iv_cnt - ivb < 4 && n < 500) begin
      step();
      n++;
    end
    repeat (20) step();
    chk("wr_stall_cs", bus.dev_cs_n, 0);
    chk("wr_stall_iv", iv_cnt - ivb, 4);
    chk("wr_stall_busy", bus.busy, 1);
    bus.wr_data  = 8'h55;
    bus.wr_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.wr_ready && n < 100);
    chk("wr_ready_1", bus.wr_ready, 1);
    bus.wr_data = 8'hAA;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.wr_ready && n < 100);
    chk("wr_ready_2", bus.wr_ready, 1);
    bus.wr_valid = 1'b0;
    wait_idle(2000);
    chk("wr_tx_count", rx_q.size() - rxb, 6);
    for (int i = 0; i < 6; i++)
      chk_tx($sformatf("wr_tx%0d", i), rxb + i, exp_wr[i], exp_wr[i], 0);
    chk("wr_no_rd_valid", rd_cnt - rdb, 0);
    chk("wr_ready_count", wrr_cnt - wb, 2);
    chk("wr_cs_rises", cs_rise - rb, 1);

    // Opcode only.
    ivb = iv_cnt; rxb = rx_q.size(); rdb = rd_cnt; clb = cs_low;
    send_cmd(8'h06, 1'b0, 24'h0, 1'b0, 0);
    wait_idle(2000);
    chk("op_iv", iv_cnt - ivb, 1);
    chk_tx("op_tx0", rxb, 8'h06, 8'h06, 0);
    chk("op_no_rd", rd_cnt - rdb, 0);
    chk("op_cs_low_min", int'((cs_low - clb) >= 101), 1);

    // Length 300 saturates to 256.
    ivb = iv_cnt; rdb = rd_cnt; lb = last_cnt;
    send_cmd(8'h0B, 1'b0, 24'h0, 1'b0, 300);
    wait_idle(5000);
    chk("sat_rd_count", rd_cnt - rdb, 256);
    chk("sat_iv", iv_cnt - ivb, 257);
    chk("sat_last_count", last_cnt - lb, 1);
    chk("sat_last_pos", last_pos - rdb, 256);
    if (rdb + 255 < rd_q.size()) begin
      chk("sat_first", rd_q[rdb], 8'hA1);
      chk("sat_final", rd_q[rdb + 255], 8'hA0);
    end

    // Async reset in the middle of a read data phase.
    rdb = rd_cnt;
    send_cmd(8'h03, 1'b1, 24'h000000, 1'b0, 8);
    n = 0;
    while (rd_cnt - rdb < 2 && n < 1000) begin
      step();
      n++;
    end
    chk("mid_reached", int'(rd_cnt - rdb >= 2), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_cs_n", bus.dev_cs_n, 1);
    chk("mid_rd_valid", bus.rd_valid, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_cmd_ready", bus.cmd_ready, 0);
    step();
    rst = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      step();
      n++;
    end
    chk("mid_to_ready", n, 50);

    // Back-to-back with cmd_valid held high.
    ivb = iv_cnt; rxb = rx_q.size(); ab = acc_cnt; rb = cs_rise;
    bus.cmd_opcode  = 8'h06;
    bus.cmd_addr_en = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_len     = '0;
    bus.cmd_valid   = 1'b1;
    n = 0;
    while (acc_cnt - ab < 2 && n < 2000) begin
      step();
      n++;
    end
    bus.cmd_valid = 1'b0;
    wait_idle(2000);
    repeat (60) step();
    chk("b2b_accepts", acc_cnt - ab, 2);
    chk("b2b_iv", iv_cnt - ivb, 2);
    chk_tx("b2b_tx0", rxb, 8'h06, 8'h06, 0);
    chk_tx("b2b_tx1", rxb + 1, 8'h06, 8'h06, 0);
    chk("b2b_cs_gap", int'(hi_gap >= 50), 1);
    chk("b2b_cs_rises", cs_rise - rb, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
